// File: rtl/sram_uart_dump_if.sv
// SRAM read port shared with the top-level mux: the dump block drives the
// address and write enable, the SRAM controller returns read data.
interface sram_uart_dump_if;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    modport master (
        output SRAM_address,
        output SRAM_we_n,
        input  SRAM_read_data
    );

    modport slave (
        input  SRAM_address,
        input  SRAM_we_n,
        output SRAM_read_data
    );
endinterface

// File: rtl/sram_uart_dump.sv
// Streams a contiguous SRAM word region out of the UART, high byte first.
// Optional SRAM_UART_DUMP_CHECKSUM_EN appends an XOR-of-all-bytes frame.
module sram_uart_dump #(
    parameter int unsigned CLOCKS_PER_BIT = 434,
    parameter int unsigned SRAM_LATENCY   = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [17:0]       Start_address,
    input  logic [17:0]       Word_count,
    sram_uart_dump_if.master  sram,
    output logic              UART_TX_O,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_TX_START,
        S_TX_DATA,
        S_TX_STOP,
        S_FINISH
    } state_t;

    localparam logic [17:0] BIT_LAST = 18'(CLOCKS_PER_BIT - 1);
    localparam logic [17:0] RD_LAST  = 18'(SRAM_LATENCY);

    state_t      state_q, state_d;
    logic [17:0] addr_q, addr_d;
    logic [17:0] left_q, left_d;
    logic [15:0] word_q, word_d;
    logic [17:0] timer_q, timer_d;
    logic [2:0]  bit_q, bit_d;
    logic        lo_q, lo_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bit_end;
    logic [7:0]  nxt_byte;
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
    logic        chk_frame_q, chk_frame_d;
    logic [7:0]  cur_byte;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        word_d  = word_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
        chk_d       = chk_q;
        chk_frame_d = chk_frame_q;
        cur_byte    = chk_frame_q ? chk_q : (lo_q ? word_q[7:0] : word_q[15:8]);
`endif
        bit_end = (timer_q == BIT_LAST);

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    busy_d  = 1'b1;
                    left_d  = Word_count;
                    timer_d = '0;
                    lo_d    = 1'b0;
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
                    chk_d = '0;
`endif
                    if (Word_count == '0) begin
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
                        chk_frame_d = 1'b1;
                        state_d     = S_TX_START;
`else
                        state_d = S_FINISH;
`endif
                    end else begin
                        addr_d  = Start_address;
                        state_d = S_READ;
                    end
                end
            end
            // Word is captured on the edge that leaves S_READ, so S_LATCH
            // only spaces the first start bit one cycle later.
            S_READ: begin
                if (timer_q == RD_LAST) begin
                    word_d  = sram.SRAM_read_data;
                    timer_d = '0;
                    state_d = S_LATCH;
                end else begin
                    timer_d = timer_q + 18'd1;
                end
            end
            S_LATCH: state_d = S_TX_START;
            S_TX_START: begin
                if (bit_end) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = S_TX_DATA;
                end else begin
                    timer_d = timer_q + 18'd1;
                end
            end
            S_TX_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) state_d = S_TX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    timer_d = timer_q + 18'd1;
                end
            end
            S_TX_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
                    if (chk_frame_q) begin
                        chk_frame_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        chk_d = chk_q ^ cur_byte;
`endif
                        if (!lo_q) begin
                            lo_d    = 1'b1;
                            state_d = S_TX_START;
                        end else begin
                            lo_d   = 1'b0;
                            left_d = left_q - 18'd1;
                            if (left_q != 18'd1) begin
                                addr_d  = addr_q + 18'd1;
                                state_d = S_READ;
                            end else begin
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
                                chk_frame_d = 1'b1;
                                state_d     = S_TX_START;
`else
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = S_IDLE;
`endif
                            end
                        end
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
                    end
`endif
                end else begin
                    timer_d = timer_q + 18'd1;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the state being entered so bit edges land on state edges.
        nxt_byte = lo_d ? word_d[7:0] : word_d[15:8];
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
        if (chk_frame_d) nxt_byte = chk_d;
`endif
        case (state_d)
            S_TX_START: tx_d = 1'b0;
            S_TX_DATA:  tx_d = nxt_byte[bit_d];
            default:    tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            word_q  <= '0;
            timer_q <= '0;
            bit_q   <= '0;
            lo_q    <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
            chk_q       <= '0;
            chk_frame_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            word_q  <= word_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            lo_q    <= lo_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
            chk_q       <= chk_d;
            chk_frame_q <= chk_frame_d;
`endif
        end
    end

    assign sram.SRAM_address = addr_q;
    assign sram.SRAM_we_n    = 1'b1;
    assign UART_TX_O         = tx_q;
    assign Busy              = busy_q;
    assign Done              = done_q;

endmodule
